// File: rtl/sync_fifo_flagged.sv
// sync_fifo_flagged: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags, sticky overflow/underflow and synchronous flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read mode; the default
// build is the standard registered-read mode.
module sync_fifo_flagged #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 512,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  input  logic [CW-1:0]    af_thresh,
  input  logic [CW-1:0]    ae_thresh,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid, r_ovf, r_udf;
  logic             w_full, w_empty, w_push, w_pop, w_load, w_udf, w_dv_next;

  assign w_full  = r_count == CW'(DEPTH);
  assign w_empty = r_count == '0;
  assign w_push  = wr_en && !w_full;

`ifdef SYNC_FIFO_FWFT_EN
  // Output register holds the head word, so the array holds count minus that word.
  logic [CW-1:0] w_mem_cnt;
  assign w_mem_cnt = r_count - CW'(r_dout_valid);
  assign w_pop     = rd_en && r_dout_valid;
  assign w_load    = (w_mem_cnt != '0) && (!r_dout_valid || w_pop);
  assign w_udf     = rd_en && !r_dout_valid;
  assign w_dv_next = w_load || (r_dout_valid && !w_pop);
`else
  assign w_pop     = rd_en && !w_empty;
  assign w_load    = w_pop;
  assign w_udf     = rd_en && w_empty;
  assign w_dv_next = w_pop;
`endif

  // Storage array: written on accepted writes, never reset.
  always_ff @(posedge clk1) begin
    if (!clr && w_push) r_mem[r_wptr] <= din;
  end

  // Pointers, occupancy, output register and sticky error flags.
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
    end else if (clr) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_dout_valid <= 1'b0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_load) begin
        r_rptr <= r_rptr + AW'(1);
        r_dout <= r_mem[r_rptr];
      end
      r_count      <= r_count + CW'(w_push) - CW'(w_pop);
      r_dout_valid <= w_dv_next;
      r_ovf        <= r_ovf | (wr_en && w_full);
      r_udf        <= r_udf | w_udf;
    end
  end

  assign dout         = r_dout;
  assign dout_valid   = r_dout_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = r_count >= af_thresh;
  assign almost_empty = r_count <= ae_thresh;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
endmodule
